// File: rtl/multicycle_main_control.sv
// Multi-cycle main control FSM for the RV32 datapath: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and ALU_OP, flags illegal opcodes and counts retired instructions.
module multicycle_main_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic [1:0]       ALU_OP,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_source,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] retired_count,
    output logic [3:0]       state_dbg
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_R_WB      = 4'd3,
        S_MEM_ADDR  = 4'd4,
        S_MEM_READ  = 4'd5,
        S_MEM_WB    = 4'd6,
        S_MEM_WRITE = 4'd7,
        S_BRANCH    = 4'd8,
        S_TRAP      = 4'd9
    } state_t;

    state_t state, state_nxt;

    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    // Outputs are held at zero for as long as rst is high, independent of the clock.
    always_comb begin
        state_nxt     = state;
        ALU_OP        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        illegal       = 1'b0;
        retire        = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    if (mem_ready) state_nxt = S_DECODE;
                end
                S_DECODE: begin
                    alu_src_b = 2'b10;
                    case (opcode)
                        OP_R:               state_nxt = S_EXEC_R;
                        OP_LOAD, OP_STORE:  state_nxt = S_MEM_ADDR;
                        OP_BRANCH:          state_nxt = S_BRANCH;
                        default:            state_nxt = S_TRAP;
                    endcase
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    ALU_OP    = 2'b10;
                    state_nxt = S_R_WB;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_nxt = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (mem_ready) state_nxt = S_MEM_WB;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                    state_nxt  = S_FETCH;
                end
                S_MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    retire    = mem_ready;
                    if (mem_ready) state_nxt = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    ALU_OP        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 1'b1;
                    retire        = 1'b1;
                    state_nxt     = S_FETCH;
                end
                S_TRAP: begin
                    illegal = 1'b1;
                end
                default: state_nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         retired_count <= '0;
        else if (retire) retired_count <= retired_count + CNT_W'(1);
    end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multi-cycle main control FSM for the RV32 datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Generates datapath enables/selects and the 2-bit ALU_OP consumed by the ALU control decoder: 00 = add, 01 = subtract, 10 = decode funct3/bit30.
- Also flags illegal opcodes and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- opcode  input  7  instruction[6:0] from the instruction register; valid from DECODE onward.
- mem_ready  input  1  memory handshake; access completes on the rising edge where mem_ready=1.
- ALU_OP  output  2  to the ALU control decoder.
- alu_src_a  output  1  0 = PC, 1 = rs1 register A.
- alu_src_b  output  2  00 = register B, 01 = constant 4, 10 = immediate.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if ALU zero.
- pc_source  output  1  0 = ALU result, 1 = ALUOut register.
- ir_write  output  1  instruction register load.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- i_or_d  output  1  memory address: 0 = PC, 1 = ALUOut.
- reg_write  output  1  register file write.
- mem_to_reg  output  1  writeback source: 0 = ALUOut, 1 = memory data register.
- illegal  output  1  sticky illegal-opcode flag.
- retire  output  1  one-cycle pulse on instruction completion.
- retired_count  output  CNT_W  retired instruction count.

Behaviour:
- Reset state and outputs:
  - State register is asynchronously reset to FETCH; retired_count resets to 0.
  - While rst=1, every control output is forced to 0, including ALU_OP=00 and illegal=0.
  - The first FETCH cycle is the first clock after rst falls.
- Outputs are Moore, decoded from the state. Any output not listed for a state is 0.
- Supported opcodes: R-type 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
- States and transitions:
  - FETCH:
    - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ALU_OP=00.
    - ir_write and pc_write equal mem_ready; they are asserted only in the completing cycle.
    - Stay while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE:
    - Outputs: alu_src_a=0, alu_src_b=10, ALU_OP=00 (branch target precomputed into ALUOut).
    - Next state: R-type -> EXEC_R; LOAD or STORE -> MEM_ADDR; BRANCH -> BRANCH; any other opcode -> TRAP.
  - EXEC_R: alu_src_a=1, alu_src_b=00, ALU_OP=10. Next: R_WB.
  - R_WB: reg_write=1, mem_to_reg=0, retire=1. Next: FETCH.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, ALU_OP=00. Next: MEM_READ for LOAD, MEM_WRITE for STORE (decided from the opcode).
  - MEM_READ: mem_read=1, i_or_d=1. Stay until mem_ready=1, then MEM_WB.
  - MEM_WB: reg_write=1, mem_to_reg=1, retire=1. Next: FETCH.
  - MEM_WRITE: mem_write=1, i_or_d=1. Stay until mem_ready=1; retire is asserted in the completing cycle; then FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, ALU_OP=01, pc_write_cond=1, pc_source=1, retire=1. Next: FETCH.
  - TRAP: illegal=1, all other outputs 0. Absorbing; only rst exits.
- Latency with mem_ready=1 at first request: R-type 4 cycles, LOAD 5, STORE 4, BRANCH 3.
- Each additional mem_ready=0 cycle adds exactly one cycle.
- Memory requests (mem_read/mem_write) are held constant while waiting; no request is dropped.
- retired_count increments by 1 on every clock where retire=1 and wraps modulo 2^CNT_W.
- Reset mid-instruction: outputs drop to 0 immediately (asynchronously), the counter clears, and the partial instruction is not retired.
- Undefined state encodings recover to FETCH on the next clock.

Test Plan:
- Reset, then R-type with mem_ready=1 -> states FETCH, DECODE, EXEC_R, R_WB; ALU_OP 00, 00, 10, xx; reg_write only in cycle 4; retire pulse in cycle 4; retired_count=1.
- LOAD with mem_ready low for 2 cycles in FETCH and 3 in MEM_READ -> 10 cycles total; ir_write/pc_write high exactly 1 cycle; mem_read steady while waiting; mem_to_reg=1 with reg_write in the final cycle.
- STORE then BRANCH back-to-back, mem_ready=1 -> 4 + 3 cycles; mem_write for 1 cycle with i_or_d=1; BRANCH cycle has ALU_OP=01, pc_write_cond=1, pc_source=1; retired_count=2.
- opcode 0010011 at DECODE -> TRAP next cycle; illegal=1 held for 20 cycles with no other output active; rst pulse -> illegal=0, FETCH resumes.
- rst asserted mid-MEM_READ -> all outputs 0 in the same cycle, retired_count=0, and no retire pulse for the aborted load.
- CNT_W=4, 17 R-type instructions -> retired_count reads 15, then 0, then 1.
